// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port RAM with a 1-cycle registered read.
// Port A has priority; port B is forced after STARVE_LIMIT consecutive contended A wins.
module mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wren,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_stall,
  output logic [DATA_W-1:0] a_q,
  output logic              a_qvalid,
  input  logic              b_req,
  input  logic              b_wren,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_q,
  output logic              b_qvalid,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_nxt_s;
  logic             starve_max_s;
  logic             gnt_a_s;
  logic             gnt_b_s;
  logic             a_qvalid_r;
  logic             b_qvalid_r;

  assign starve_max_s = (starve_cnt_r == LIMIT_C);

  // Grant decision: A wins contention until its streak reaches the limit.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (reset) begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end else begin
      case ({a_req, b_req})
        2'b10: gnt_a_s = 1'b1;
        2'b01: gnt_b_s = 1'b1;
        2'b11: begin
          if (starve_max_s) begin
            gnt_b_s = 1'b1;
          end else begin
            gnt_a_s = 1'b1;
          end
        end
        default: begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
      endcase
    end
  end

  // Streak counter next value; saturation guard keeps it bounded even if misused.
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (a_req && b_req && gnt_a_s) begin
      if (starve_max_s) begin
        starve_nxt_s = starve_cnt_r;
      end else begin
        starve_nxt_s = starve_cnt_r + CNT_W'(1);
      end
    end else begin
      starve_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Streak counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // RAM request mux; idle cycles present port A fields.
  always_comb begin
    ram_addr   = a_addr;
    ram_dataIn = a_data;
    if (gnt_b_s) begin
      ram_addr   = b_addr;
      ram_dataIn = b_data;
    end else begin
      ram_addr   = a_addr;
      ram_dataIn = a_data;
    end
  end

  assign ram_wEn = (gnt_a_s & a_wren) | (gnt_b_s & b_wren);
  assign a_stall = ~reset & a_req & ~gnt_a_s;
  assign b_gnt   = gnt_b_s;

  // Read-valid strobes track the RAM's one-cycle registered read.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_qvalid_r <= 1'b0;
      b_qvalid_r <= 1'b0;
    end else begin
      a_qvalid_r <= gnt_a_s & ~a_wren;
      b_qvalid_r <= gnt_b_s & ~b_wren;
    end
  end

  assign a_qvalid = a_qvalid_r;
  assign b_qvalid = b_qvalid_r;
  assign a_q      = ram_dataOut;
  assign b_q      = ram_dataOut;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a behavioural model
// (win-streak count, pending-read list, shadow memory of written words).
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_wren, b_req, b_wren;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_stall, a_qvalid, b_gnt, b_qvalid, ram_wEn;
  logic [DW-1:0] a_q, b_q, ram_dataIn, ram_dataOut;
  logic [AW-1:0] ram_addr;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_data(a_data),
    .a_stall(a_stall), .a_q(a_q), .a_qvalid(a_qvalid),
    .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_data(b_data),
    .b_gnt(b_gnt), .b_q(b_q), .b_qvalid(b_qvalid),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  always #5 clock = ~clock;

  // Single-port RAM with registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model state.
  int            a_streak = 0;
  bit            pend_a = 1'b0, pend_b = 1'b0;
  bit            pend_a_known = 1'b0, pend_b_known = 1'b0;
  logic [DW-1:0] pend_a_data, pend_b_data;
  logic [DW-1:0] shadow [int];

  always @(negedge clock) begin
    if (model_on) begin
      bit            ga, gb;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] edata;
      if (reset) begin
        ga = 1'b0; gb = 1'b0;
      end else if (a_req && b_req) begin
        gb = (a_streak == LIMIT);
        ga = !gb;
      end else begin
        ga = a_req; gb = b_req;
      end
      eaddr = gb ? b_addr : a_addr;
      edata = gb ? b_data : a_data;
      check("a_stall", a_stall, (!reset && a_req && !ga));
      check("b_gnt", b_gnt, gb);
      check("ram_wEn", ram_wEn, (ga && a_wren) || (gb && b_wren));
      check("ram_addr", ram_addr, eaddr);
      check("ram_dataIn", ram_dataIn, edata);
      check("a_qvalid", a_qvalid, pend_a);
      check("b_qvalid", b_qvalid, pend_b);
      if (pend_a && pend_a_known) check("a_q", a_q, pend_a_data);
      if (pend_b && pend_b_known) check("b_q", b_q, pend_b_data);
      if (reset) begin
        a_streak = 0; pend_a = 1'b0; pend_b = 1'b0;
      end else begin
        a_streak = (a_req && b_req && ga) ? a_streak + 1 : 0;
        pend_a = ga && !a_wren;
        pend_b = gb && !b_wren;
        pend_a_known = shadow.exists(int'(a_addr));
        pend_b_known = shadow.exists(int'(b_addr));
        if (pend_a_known) pend_a_data = shadow[int'(a_addr)];
        if (pend_b_known) pend_b_data = shadow[int'(b_addr)];
        if ((ga && a_wren) || (gb && b_wren)) shadow[int'(eaddr)] = edata;
      end
    end
  end

  task automatic set_in(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req = ar; a_wren = aw; a_addr = aa; a_data = ad;
    b_req = br; b_wren = bw; b_addr = ba; b_data = bd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  initial begin
    logic [11:0] pat12;
    logic [8:0]  pat9;
    bit a_held, b_held;
    reset = 1'b1;
    idle();
    step();
    model_on = 1'b1;
    a_req = 1'b1; a_wren = 1'b1;
    @(negedge clock);
    check("rst_wen", ram_wEn, 1'b0);
    check("rst_stall", a_stall, 1'b0);
    check("rst_bgnt", b_gnt, 1'b0);
    check("rst_aqv", a_qvalid, 1'b0);
    check("rst_bqv", b_qvalid, 1'b0);
    step();
    reset = 1'b0; idle(); step();

    // A write then read of 0x010
    set_in(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 32'h0);
    @(negedge clock); check("a_wr_wen", ram_wEn, 1'b1); check("a_wr_stall", a_stall, 1'b0);
    step();
    set_in(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    @(negedge clock); check("a_rd_stall", a_stall, 1'b0); check("a_rd_wen", ram_wEn, 1'b0);
    step();
    idle();
    @(negedge clock); check("a_rd_qv", a_qvalid, 1'b1); check("a_rd_q", a_q, 32'hDEADBEEF);
    step();

    // B write then read at top address
    set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'hFFF, 32'h00000001);
    @(negedge clock); check("b_wr_gnt", b_gnt, 1'b1); check("b_wr_addr", ram_addr, 12'hFFF);
    step();
    set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'hFFF, 32'h0);
    @(negedge clock); check("b_rd_gnt", b_gnt, 1'b1);
    step();
    idle();
    @(negedge clock); check("b_rd_qv", b_qvalid, 1'b1); check("b_rd_q", b_q, 32'h00000001);
    step();

    // Sustained contention: AAAABAAAABAA
    pat12 = 12'h000;
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b0, 12'hFFF, 32'h0);
      @(negedge clock);
      pat12[i] = b_gnt;
      if (i == 4) check("sw_aqv", a_qvalid, 1'b1);
      if (i == 5) begin check("sw_bqv", b_qvalid, 1'b1); check("sw_bq", b_q, 32'h00000001); end
      step();
    end
    check("pattern12", pat12, 12'h210);
    idle(); step();

    // Contention broken by one cycle of b_req low restarts the streak
    pat9 = 9'h000;
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'b0, 12'h010, 32'h0, (i != 3), 1'b0, 12'hFFF, 32'h0);
      @(negedge clock);
      pat9[i] = b_gnt;
      step();
    end
    check("pattern9", pat9, 9'h100);
    idle(); step();

    // Reset right after a granted A read
    set_in(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    step();
    reset = 1'b1;
    set_in(1'b1, 1'b1, 12'h030, 32'h00000055, 1'b0, 1'b0, 12'h000, 32'h0);
    @(negedge clock); check("mid_rst_wen", ram_wEn, 1'b0); check("mid_rst_stall", a_stall, 1'b0);
    step();
    @(negedge clock); check("mid_rst_aqv", a_qvalid, 1'b0);
    reset = 1'b0; idle();
    step();
    @(negedge clock); check("post_rst_aqv", a_qvalid, 1'b0); check("post_rst_bqv", b_qvalid, 1'b0);
    step();

    // A write while B waits, then B read of the same word
    set_in(1'b1, 1'b1, 12'h020, 32'hCAFE0001, 1'b1, 1'b0, 12'h020, 32'h0);
    @(negedge clock); check("aw_b_gnt", b_gnt, 1'b0); check("aw_wen", ram_wEn, 1'b1);
    step();
    set_in(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
    @(negedge clock); check("aw_no_aqv", a_qvalid, 1'b0); check("br_gnt", b_gnt, 1'b1);
    step();
    idle();
    @(negedge clock); check("br_qv", b_qvalid, 1'b1); check("br_q", b_q, 32'hCAFE0001);
    check("br_no_aqv", a_qvalid, 1'b0);
    step();

    // Randomized traffic honoring hold-until-granted
    a_held = 1'b0; b_held = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (reset) begin
        a_held = 1'b0; b_held = 1'b0;
      end
      if (!a_held) begin
        a_req  = ($urandom_range(0, 3) != 0);
        a_wren = $urandom_range(0, 1);
        a_addr = ($urandom_range(0, 9) == 0) ? 12'hFFF : AW'($urandom_range(0, 15));
        a_data = $urandom;
      end
      if (!b_held) begin
        b_req  = ($urandom_range(0, 2) != 0);
        b_wren = $urandom_range(0, 1);
        b_addr = ($urandom_range(0, 9) == 0) ? 12'hFFF : AW'($urandom_range(0, 15));
        b_data = $urandom;
      end
      @(negedge clock);
      a_held = !reset && a_req && a_stall;
      b_held = !reset && b_req && !b_gnt;
      step();
    end
    reset = 1'b0; idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
